// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART data width and tx drain FSM state type
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DEPTH x UART_DW synchronous FIFO storage with wrap-bit pointers
module sync_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [UART_DW-1:0] push_data,
  input  logic               pop,
  output logic [UART_DW-1:0] pop_data,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level
);

  logic [UART_DW-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  // Status is a pure function of the registered pointers, so it reflects the last edge.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that paces bytes into uart_send on tx_busy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BUSY_TMO = 8,
  localparam int LW      = $clog2(DEPTH) + 1,
  localparam int TW      = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  output logic               full,
  output logic               empty,
  output logic [LW-1:0]      level,
  output logic               overflow,
  input  logic               ovf_clr,
  input  logic               tx_busy,
  output logic               send_en,
  output logic [UART_DW-1:0] send_data
);

  tx_state_e          state_q, state_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               send_en_d;
  logic [UART_DW-1:0] send_data_d;
  logic [UART_DW-1:0] pop_data;
  logic               pop;

  sync_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // FSM state, timeout counter and registered uart_send drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      send_en   <= 1'b0;
      send_data <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      send_en   <= send_en_d;
      send_data <= send_data_d;
    end
  end

  // Next state: launch only when the line is free, then wait for busy to rise and fall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    send_en_d   = 1'b0;
    send_data_d = send_data;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop         = 1'b1;
          send_en_d   = 1'b1;
          send_data_d = pop_data;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TW'(BUSY_TMO - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH    = 16;
  localparam int BUSY_TMO = 8;
  localparam int BUSY_LEN = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       ext_busy = 1'b0;
  logic       model_on = 1'b1;
  logic       model_busy = 1'b0;
  logic       tx_busy;
  logic       full, empty, overflow, send_en;
  logic [4:0] level;
  logic [7:0] send_data;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int busy_cnt = 0;
  int busy_viol = 0;
  int last_pulse = -100;
  int min_diff = 1000;
  logic [7:0] sent_q[$];
  int sent_cyc[$];

  assign tx_busy = model_busy | ext_busy;

  uart_tx_fifo #(
    .DEPTH    (DEPTH),
    .BUSY_TMO (BUSY_TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .tx_busy   (tx_busy),
    .send_en   (send_en),
    .send_data (send_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // uart_send model: busy rises one cycle after the enable pulse, lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    if (model_on && send_en) begin
      model_busy <= 1'b1;
      busy_cnt   <= BUSY_LEN;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_busy <= 1'b0;
    end
  end

  // Capture every launched byte with its cycle number.
  always @(negedge clk) begin
    if (send_en) begin
      sent_q.push_back(send_data);
      sent_cyc.push_back(cycle);
      if (model_busy) busy_viol++;
      if (cycle - last_pulse < min_diff) min_diff = cycle - last_pulse;
      last_pulse = cycle;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int limit, input string tag);
    int k;
    k = 0;
    while (sent_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(sent_q.size()), 32'(n));
  endtask

  task automatic clear_log();
    sent_q.delete();
    sent_cyc.delete();
    last_pulse = -100;
    min_diff   = 1000;
    busy_viol  = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_send_en", 32'(send_en), 32'd0);
    check("rst_send_data", 32'(send_data), 32'h00);
    rst = 1'b0;

    // Single byte latency
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    check("one_level_after_push", 32'(level), 32'd1);
    check("one_no_early_en", 32'(send_en), 32'd0);
    @(negedge clk);
    check("one_send_en", 32'(send_en), 32'd1);
    check("one_send_data", 32'(send_data), 32'hA5);
    check("one_empty_after_pop", 32'(empty), 32'd1);
    @(negedge clk);
    check("one_pulse_single", 32'(send_en), 32'd0);
    wait_sent(1, 20, "one_sent_count");
    repeat (20) @(negedge clk);
    clear_log();

    // Burst into a FIFO held off by a foreign transmit
    ext_busy = 1'b1;
    push_burst(8'h00, 16);
    check("burst_full", 32'(full), 32'd1);
    check("burst_level", 32'(level), 32'd16);
    repeat (5) @(negedge clk);
    check("busy_hold_no_en", 32'(sent_q.size()), 32'd0);

    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level_kept", 32'(level), 32'd16);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hFE;
    @(negedge clk);
    ovf_clr = 1'b0;
    wr_en = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr2", 32'(overflow), 32'd0);

    // Release busy and push while full in the same cycle as the first pop
    ext_busy = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    check("pop_push_ovf", 32'(overflow), 32'd1);
    check("pop_push_level", 32'(level), 32'd15);
    check("pop_push_en", 32'(send_en), 32'd1);
    check("pop_push_data", 32'(send_data), 32'h00);

    wait_sent(16, 1000, "burst_sent_count");
    repeat (30) @(negedge clk);
    check("burst_no_extra", 32'(sent_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent_q.size(); i++) begin
      check($sformatf("burst_order_%0d", i), 32'(sent_q[i]), 32'(i));
    end
    check("burst_busy_low_at_en", 32'(busy_viol), 32'd0);
    check("burst_min_gap_ok", 32'(min_diff >= 3), 32'd1);
    check("burst_empty_end", 32'(empty), 32'd1);
    clear_log();

    // Timeout: uart_send never acknowledges
    model_on = 1'b0;
    push_burst(8'h11, 2);
    wait_sent(2, 100, "tmo_sent_count");
    if (sent_q.size() == 2) begin
      check("tmo_byte0", 32'(sent_q[0]), 32'h11);
      check("tmo_byte1", 32'(sent_q[1]), 32'h12);
      check("tmo_spacing", 32'(sent_cyc[1] - sent_cyc[0]), 32'd10);
    end
    repeat (20) @(negedge clk);
    model_on = 1'b1;
    clear_log();

    // Reset while a byte is on the line and five are queued
    push_burst(8'h30, 6);
    check("mid_level_before_rst", 32'(level), 32'd5);
    check("mid_sent_before_rst", 32'(sent_q.size()), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_send_en", 32'(send_en), 32'd0);
    check("mid_rst_send_data", 32'(send_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_no_en_after_rel", 32'(sent_q.size()), 32'd1);
    push_burst(8'h5A, 1);
    wait_sent(2, 50, "mid_new_push_sent");
    if (sent_q.size() == 2) check("mid_new_data", 32'(sent_q[1]), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
